// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: prescaler, digit counter, per-frame snapshot.
// Define SEG_SCAN_LZ_BLANK_EN to build leading-zero suppression on the anode drive.
module seg_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int NIB_W       = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int SEL_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [DIGITS*NIB_W-1:0]   inVal,
  input  logic [DIGITS-1:0]         blank_mask,
  output logic [NIB_W-1:0]          hexVal,
  output logic [DIGITS-1:0]         anode,
  output logic [SEL_W-1:0]          digit_sel,
  output logic                      frame_start
);

  localparam int WORD_W = DIGITS * NIB_W;
  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  logic [PRE_W-1:0]  pre_reg, pre_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [WORD_W-1:0] snap_reg, snap_next;
  logic              loaded_reg, loaded_next;
  logic [NIB_W-1:0]  hex_reg, hex_next;
  logic [DIGITS-1:0] anode_reg, anode_next;
  logic              fs_reg, fs_next;

  logic tick, wrap, load;
  logic [NIB_W-1:0]  nib_next [DIGITS];
  logic [DIGITS-1:0] lz_dark;

  always_comb begin
    pre_next    = pre_reg;
    sel_next    = sel_reg;
    snap_next   = snap_reg;
    loaded_next = loaded_reg;
    tick        = 1'b0;
    wrap        = 1'b0;
    load        = 1'b0;
    if (enable) begin
      tick = (pre_reg == PRE_LAST);
      wrap = tick && (sel_reg == SEL_LAST);
      pre_next = tick ? '0 : pre_reg + PRE_W'(1);
      if (tick) begin
        sel_next = wrap ? '0 : sel_reg + SEL_W'(1);
      end
      // A wrap tick samples inVal on the same edge the counter returns to digit 0.
      load = !loaded_reg || wrap;
      if (load) begin
        snap_next = inVal;
      end
      loaded_next = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib_next[gi] = snap_next[gi*NIB_W +: NIB_W];
    end
  endgenerate

`ifdef SEG_SCAN_LZ_BLANK_EN
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz_dark[gi] = 1'b0;
      end else begin : g_rest
        // Dark when this nibble and every more-significant one are zero.
        assign lz_dark[gi] = ~(|snap_next[WORD_W-1 : gi*NIB_W]);
      end
    end
  endgenerate
`else
  assign lz_dark = '0;
`endif

  always_comb begin
    hex_next = nib_next[sel_next];
    fs_next  = load;
  end

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_anode
      assign anode_next[gi] = ~(enable && (sel_next == SEL_W'(gi))
                                && !blank_mask[gi] && !lz_dark[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_reg    <= '0;
      sel_reg    <= '0;
      snap_reg   <= '0;
      loaded_reg <= 1'b0;
      hex_reg    <= '0;
      anode_reg  <= '1;
      fs_reg     <= 1'b0;
    end else begin
      pre_reg    <= pre_next;
      sel_reg    <= sel_next;
      snap_reg   <= snap_next;
      loaded_reg <= loaded_next;
      hex_reg    <= hex_next;
      anode_reg  <= anode_next;
      fs_reg     <= fs_next;
    end
  end

  assign hexVal      = hex_reg;
  assign anode       = anode_reg;
  assign digit_sel   = sel_reg;
  assign frame_start = fs_reg;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised, time-multiplexed display scanner. Successor to the fixed 8-nibble combinational selector.
- Owns its own refresh prescaler and digit counter. Snapshots the input word once per frame so a value cannot change partway through a scan.
- Drives one nibble plus a one-hot active-low anode vector to the seven-segment decoder and board pins.
- Adds enable, per-digit blanking and a frame-start strobe.

Parameters:
- DIGITS, 8, number of digits scanned; any value >= 1, not required to be a power of two.
- NIB_W, 4, bits per digit value.
- REFRESH_DIV, 50000, clk cycles each digit is held; any value >= 1.
- SEL_W, max(1, clog2(DIGITS)), width of digit_sel (derived, do not override).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  1 = scan; 0 = freeze counters and blank every anode.
- inVal  input  DIGITS*NIB_W  packed digit values; digit i = inVal[i*NIB_W +: NIB_W].
- blank_mask  input  DIGITS  bit i = 1 forces digit i dark.
- hexVal  output  NIB_W  nibble of the currently selected digit (registered).
- anode  output  DIGITS  active-low one-hot digit enable (registered).
- digit_sel  output  SEL_W  index of the current digit (registered).
- frame_start  output  1  one-cycle pulse at the start of each frame (registered).

Behaviour:
- Reset (reset_n = 0 at a clk edge; overrides all other inputs, including mid-frame):
  - prescaler = 0, digit_sel = 0, snap = 0, loaded = 0.
  - hexVal = 0, anode = all ones, frame_start = 0.
- Prescaler:
  - Counts 0 .. REFRESH_DIV-1 while enable = 1, then wraps to 0.
  - tick = (enable && prescaler == REFRESH_DIV-1).
  - REFRESH_DIV = 1 gives tick on every enabled cycle.
- Digit counter: on tick, digit_sel increments; at DIGITS-1 it wraps to 0. Values >= DIGITS are never reached.
- Snapshot register snap (DIGITS*NIB_W):
  - Loads inVal on the first enabled cycle with loaded = 0; sets loaded = 1.
  - Also loads inVal on every wrap tick (digit_sel DIGITS-1 -> 0).
  - inVal changes at any other time have no visible effect until the next wrap.
- frame_start = 1 for exactly one cycle on each snapshot load, aligned with digit_sel = 0 and the new hexVal.
- Outputs are computed from next-state values and registered on the same edge as digit_sel, so hexVal, anode and digit_sel are mutually consistent every cycle. Zero extra latency beyond the register.
  - hexVal = snap[digit_sel*NIB_W +: NIB_W].
  - anode[i] = 0 only when i == digit_sel, enable = 1, blank_mask[i] = 0, and the digit is not blanked by the optional feature; otherwise 1.
  - Blanking affects anode only; hexVal still shows the digit value.
- enable = 0:
  - prescaler, digit_sel, snap and loaded hold.
  - anode = all ones on the next edge; frame_start = 0.
  - When enable returns to 1, scanning resumes from the held state. No restart, no new snapshot unless loaded = 0.
- Simultaneous events:
  - reset_n = 0 wins over everything.
  - A wrap tick that coincides with an inVal change captures the new inVal.
- DIGITS = 1: digit_sel stays 0; frame_start pulses on every tick.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression, computed from snap.
  - Digit i (i >= 1) is dark when snap nibbles i .. DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - Combined with blank_mask by OR.
- Undefined: no suppression logic is built; only enable and blank_mask affect anode.

Test Plan:
- Basic scan: DIGITS=8, REFRESH_DIV=4, inVal=32'h8765_4321, enable=1.
  - digit_sel steps 0..7, each held 4 cycles.
  - hexVal = 1,2,...,8.
  - anode = FE, FD, FB, ..., 7F.
  - frame_start pulses every 32 cycles.
- Tear-free: change inVal to 32'hFFFF_FFFF while digit_sel = 3.
  - hexVal for digits 4..7 stays 5..8.
  - Next frame shows F for every digit.
- Non-power-of-2 / enable: DIGITS=6, REFRESH_DIV=1.
  - digit_sel runs 0..5 then 0; never reaches 6 or 7.
  - Deassert enable at digit_sel = 2: anode = 6'h3F next cycle and digit_sel holds 2.
  - Reassert enable: scan resumes at digit_sel = 2.
- Reset mid-operation: assert reset_n = 0 at digit_sel = 5.
  - Next edge: digit_sel = 0, anode = FF, hexVal = 0, frame_start = 0.
  - First enabled cycle after release snapshots inVal and pulses frame_start.
- Blank mask: blank_mask = 8'h81.
  - anode stays FF while digit_sel is 0 or 7.
  - hexVal still shows 1 and 8.
- LZ blank (SEG_SCAN_LZ_BLANK_EN defined): inVal = 32'h0000_00A0.
  - Digits 0 and 1 light (hexVal 0, A).
  - Digits 2..7 keep anode = FF.
  - With inVal = 0, only digit 0 lights.
